// File: rtl/fpnew_resp_pkg.sv
// Shared constants for the FPNew response queue: status width and IEEE flag positions.
package fpnew_resp_pkg;

  localparam int STATUS_W = 5;
  localparam int FLAG_NV  = 4;
  localparam int FLAG_DZ  = 3;
  localparam int FLAG_OF  = 2;
  localparam int FLAG_UF  = 1;
  localparam int FLAG_NX  = 0;

  // A clear in the same cycle as an accepted beat keeps the new beat's flags.
  function automatic logic [STATUS_W-1:0] next_fflags(
    input logic                clr,
    input logic                acc,
    input logic [STATUS_W-1:0] cur,
    input logic [STATUS_W-1:0] status
  );
    logic [STATUS_W-1:0] base;
    base = clr ? '0 : cur;
    return acc ? (base | status) : base;
  endfunction

endpackage

// File: rtl/fpnew_resp_fifo.sv
// In-order storage for response beats: register array, wrapping pointers, explicit count.
module fpnew_resp_fifo #(
  parameter int WIDTH = 71,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok, pop_ok;

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  assign rdata_o = mem[rd_ptr];
  assign count_o = count;

endmodule

// File: rtl/fpnew_resp_queue.sv
// FPNew response stage: queues FPU result beats for the consumer and accumulates sticky fflags.
// Build option FPNEW_RESP_BYPASS_EN: empty queue + ready consumer passes a beat through in 0 cycles.
module fpnew_resp_queue
  import fpnew_resp_pkg::*;
#(
  parameter int FLEN      = 64,
  parameter int TAG_WIDTH = 2,
  parameter int DEPTH     = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 fpu_valid_i,
  output logic                 fpu_ready_o,
  input  logic [FLEN-1:0]      fpu_result_i,
  input  logic [STATUS_W-1:0]  fpu_status_i,
  input  logic [TAG_WIDTH-1:0] fpu_tag_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [FLEN-1:0]      rsp_result_o,
  output logic [STATUS_W-1:0]  rsp_status_o,
  output logic [TAG_WIDTH-1:0] rsp_tag_o,
  output logic [STATUS_W-1:0]  fflags_o,
  input  logic                 fflags_clr_i,
  output logic [CW-1:0]        count_o
);

  localparam int EW = FLEN + STATUS_W + TAG_WIDTH;

  logic [EW-1:0]       in_beat, head_beat, out_beat;
  logic                full, empty, accept, bypass, push, pop;
  logic [STATUS_W-1:0] fflags;

  assign in_beat = {fpu_result_i, fpu_status_i, fpu_tag_i};

  // Ready depends only on registered occupancy, never on the consumer side.
  assign fpu_ready_o = ~full;
  assign accept      = fpu_valid_i & fpu_ready_o & ~flush_i;

`ifdef FPNEW_RESP_BYPASS_EN
  assign bypass = fpu_valid_i & empty & ~flush_i & rsp_ready_i;
`else
  assign bypass = 1'b0;
`endif

  assign push = accept & ~bypass;
  assign pop  = ~empty & rsp_ready_i & ~flush_i;

  fpnew_resp_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_beat),
    .rdata_o (head_beat),
    .count_o (count_o),
    .full_o  (full),
    .empty_o (empty)
  );

  assign rsp_valid_o = ~empty | bypass;
  assign out_beat    = bypass ? in_beat : head_beat;
  assign {rsp_result_o, rsp_status_o, rsp_tag_o} = out_beat;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fflags <= '0;
    else         fflags <= next_fflags(fflags_clr_i, accept, fflags, fpu_status_i);
  end

  assign fflags_o = fflags;

endmodule
